// File: rtl/ps2_digit_receiver.sv
// PS/2 keyboard receiver that assembles NUM_DIGITS decimal key presses into one packed entry.
// Optional odd-parity frame checking is built only when PS2_PARITY_CHECK_EN is defined.
//
// state   | meaning
// NORMAL  | waiting for a make code, E0 or F0 prefix
// BRK     | F0 seen, next code is a break code and is dropped
// EXT     | E0 seen, next code is an extended key or F0
// EXT_BRK | E0 F0 seen, next code is dropped
module ps2_digit_receiver #(
  parameter int NUM_DIGITS     = 4,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    PS2Clk,
  input  logic                    PS2Data,
  output logic [4*NUM_DIGITS-1:0] userInt,
  output logic                    ready,
  output logic [3:0]              digit_count,
  output logic                    frame_err
);

  localparam int             TW       = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0]  TMO_LOAD = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]     LAST     = 4'(NUM_DIGITS - 1);

  typedef enum logic [1:0] {NORMAL, BRK, EXT, EXT_BRK} state_t;

  logic [SYNC_STAGES-1:0]  r_clk_sync;
  logic [SYNC_STAGES-1:0]  r_data_sync;
  logic                    r_clk_prev;
  logic [8:0]              r_frame;
  logic                    r_stop;
  logic [3:0]              r_bit_cnt;
  logic [TW-1:0]           r_tmo;
  state_t                  r_state;
  logic [4*NUM_DIGITS-1:0] r_buf;
  logic [3:0]              r_cnt;
  logic [4*NUM_DIGITS-1:0] r_user;
  logic                    r_ready;
  logic                    r_ferr;

  logic                    w_clk_s;
  logic                    w_data_s;
  logic                    w_fall;
  logic                    w_frame_done;
  logic                    w_par_ok;
  logic                    w_valid;
  logic                    w_timeout;
  logic [7:0]              w_code;
  logic                    w_is_digit;
  logic [3:0]              w_digit;
  logic [4*NUM_DIGITS-1:0] w_buf_app;
  logic [4*NUM_DIGITS-1:0] w_buf_bs;
  state_t                  w_state_nxt;
  logic [4*NUM_DIGITS-1:0] w_buf_nxt;
  logic [3:0]              w_cnt_nxt;
  logic [4*NUM_DIGITS-1:0] w_user_nxt;
  logic                    w_ready_nxt;

  assign w_clk_s      = r_clk_sync[SYNC_STAGES-1];
  assign w_data_s     = r_data_sync[SYNC_STAGES-1];
  assign w_fall       = r_clk_prev & ~w_clk_s;
  assign w_frame_done = (r_bit_cnt == 4'd11);
  assign w_code       = r_frame[8:1];

`ifdef PS2_PARITY_CHECK_EN
  logic r_par;
  assign w_par_ok = ^{r_frame[8:1], r_par};
`else
  assign w_par_ok = 1'b1;
`endif

  assign w_valid   = w_frame_done & ~r_frame[0] & r_stop & w_par_ok;
  // A frame completing or a new edge arriving always wins over the idle timeout.
  assign w_timeout = (r_bit_cnt != 4'd0) & ~w_frame_done & ~w_fall & (r_tmo == '0);

  always_comb begin
    w_is_digit = 1'b1;
    w_digit    = 4'd0;
    case (w_code)
      8'h16:   w_digit = 4'd1;
      8'h1E:   w_digit = 4'd2;
      8'h26:   w_digit = 4'd3;
      8'h25:   w_digit = 4'd4;
      8'h2E:   w_digit = 4'd5;
      8'h36:   w_digit = 4'd6;
      8'h3D:   w_digit = 4'd7;
      8'h3E:   w_digit = 4'd8;
      8'h46:   w_digit = 4'd9;
      8'h45:   w_digit = 4'd0;
      default: w_is_digit = 1'b0;
    endcase
  end

  always_comb begin
    w_buf_app = r_buf;
    w_buf_bs  = r_buf;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (r_cnt == 4'(k))     w_buf_app[4*k +: 4] = w_digit;
      if (r_cnt == 4'(k + 1)) w_buf_bs[4*k +: 4]  = 4'd0;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_buf_nxt   = r_buf;
    w_cnt_nxt   = r_cnt;
    w_user_nxt  = r_user;
    w_ready_nxt = 1'b0;
    if (w_valid) begin
      case (r_state)
        NORMAL: begin
          if (w_code == 8'hF0) begin
            w_state_nxt = BRK;
          end else if (w_code == 8'hE0) begin
            w_state_nxt = EXT;
          end else if (w_is_digit) begin
            if (r_cnt == LAST) begin
              w_user_nxt  = w_buf_app;
              w_ready_nxt = 1'b1;
              w_buf_nxt   = '0;
              w_cnt_nxt   = 4'd0;
            end else begin
              w_buf_nxt = w_buf_app;
              w_cnt_nxt = r_cnt + 4'd1;
            end
          end else if (w_code == 8'h66 && r_cnt != 4'd0) begin
            w_buf_nxt = w_buf_bs;
            w_cnt_nxt = r_cnt - 4'd1;
          end
        end
        EXT:     w_state_nxt = (w_code == 8'hF0) ? EXT_BRK : NORMAL;
        default: w_state_nxt = NORMAL;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) r_state <= NORMAL;
    else      r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_clk_sync  <= '1;
      r_data_sync <= '1;
      r_clk_prev  <= 1'b1;
      r_frame     <= '0;
      r_stop      <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
      r_par       <= 1'b0;
`endif
      r_bit_cnt   <= 4'd0;
      r_tmo       <= '0;
      r_buf       <= '0;
      r_cnt       <= 4'd0;
      r_user      <= '0;
      r_ready     <= 1'b0;
      r_ferr      <= 1'b0;
    end else begin
      r_clk_sync  <= {r_clk_sync[SYNC_STAGES-2:0], PS2Clk};
      r_data_sync <= {r_data_sync[SYNC_STAGES-2:0], PS2Data};
      r_clk_prev  <= w_clk_s;

      if (w_frame_done || w_timeout) begin
        r_bit_cnt <= 4'd0;
      end else if (w_fall) begin
        case (r_bit_cnt)
          4'd9: begin
`ifdef PS2_PARITY_CHECK_EN
            r_par <= w_data_s;
`endif
          end
          4'd10:   r_stop <= w_data_s;
          default: r_frame[r_bit_cnt] <= w_data_s;
        endcase
        r_bit_cnt <= r_bit_cnt + 4'd1;
      end

      if (r_bit_cnt == 4'd0 || w_fall || w_frame_done) r_tmo <= TMO_LOAD;
      else if (r_tmo != '0)                            r_tmo <= r_tmo - 1'b1;

      r_buf   <= w_buf_nxt;
      r_cnt   <= w_cnt_nxt;
      r_user  <= w_user_nxt;
      r_ready <= w_ready_nxt;
      r_ferr  <= (w_frame_done & ~w_valid) | w_timeout;
    end
  end

  assign userInt     = r_user;
  assign ready       = r_ready;
  assign digit_count = r_cnt;
  assign frame_err   = r_ferr;

endmodule

// File: tb/tb_ps2_digit_receiver.sv
// Self-checking bench for ps2_digit_receiver: directed scenarios followed by random key traffic
// compared against a queue-based keyboard model; follows PS2_PARITY_CHECK_EN like the design.
module tb_ps2_digit_receiver;
  localparam int ND  = 4;
  localparam int TMO = 64;
  localparam int SS  = 2;
`ifdef PS2_PARITY_CHECK_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          PS2Clk = 1'b1;
  logic          PS2Data = 1'b1;
  logic [4*ND-1:0] userInt;
  logic          ready;
  logic [3:0]    digit_count;
  logic          frame_err;

  ps2_digit_receiver #(.NUM_DIGITS(ND), .TIMEOUT_CYCLES(TMO), .SYNC_STAGES(SS)) dut (
    .clk(clk), .rst(rst), .PS2Clk(PS2Clk), .PS2Data(PS2Data),
    .userInt(userInt), .ready(ready), .digit_count(digit_count), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int n_ready  = 0;
  int n_ferr   = 0;
  logic [4*ND-1:0] prev_user = '0;

  int          q[$];
  bit          m_skip = 1'b0;
  bit          m_ext  = 1'b0;
  logic [15:0] exp_user = '0;
  int          exp_ready = 0;
  int          exp_ferr  = 0;
  logic [7:0]  dcodes[10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
  logic [7:0]  pool[15] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46,
                            8'hF0, 8'hE0, 8'h66, 8'h1C, 8'h5A};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    assert (got === want) else begin
      n_errors++;
      $error("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (rst === 1'b1) begin
      if (ready === 1'b1) n_ready++;
      if (frame_err === 1'b1) n_ferr++;
      check("ready_ferr_excl", 32'(ready & frame_err), 32'd0);
      check("user_only_on_ready", 32'((userInt !== prev_user) && (ready !== 1'b1)), 32'd0);
    end
    prev_user = userInt;
  end

  task automatic model_key(input logic [7:0] c);
    int d = -1;
    for (int i = 0; i < 10; i++) if (dcodes[i] == c) d = i;
    if (m_skip) m_skip = 1'b0;
    else if (m_ext) begin
      m_ext = 1'b0;
      if (c == 8'hF0) m_skip = 1'b1;
    end
    else if (c == 8'hF0) m_skip = 1'b1;
    else if (c == 8'hE0) m_ext = 1'b1;
    else if (d >= 0) begin
      q.push_back(d);
      if (q.size() == ND) begin
        exp_user = '0;
        foreach (q[i]) exp_user |= 16'(q[i]) << (4 * i);
        exp_ready++;
        q.delete();
      end
    end
    else if (c == 8'h66 && q.size() > 0) void'(q.pop_back());
  endtask

  function automatic logic [10:0] mk_frame(input logic [7:0] c, input bit par_bad, input bit stop_bad);
    bit p;
    p = ~(^c);
    if (par_bad) p = ~p;
    return {~stop_bad, p, c, 1'b0};
  endfunction

  // One PS/2 bit, 16 clk period; lat = negedges after the falling edge until ready/frame_err.
  task automatic ps2_bit(input bit b, output int lat);
    lat = -1;
    PS2Data = b;
    repeat (4) @(negedge clk);
    PS2Clk = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (lat < 0 && (ready === 1'b1 || frame_err === 1'b1)) lat = i;
    end
    PS2Clk = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic send_raw(input logic [10:0] f, input int nbits, output int lat);
    int l;
    lat = -1;
    for (int i = 0; i < nbits; i++) begin
      ps2_bit(f[i], l);
      if (i == nbits - 1) lat = l;
    end
  endtask

  // kind: 0 good frame, 1 bad stop bit, 2 wrong parity bit
  task automatic key(input logic [7:0] c, input int kind, input string tag);
    bit valid;
    int lat;
    int r0;
    valid = (kind == 0) || (kind == 2 && !PAR_EN);
    r0 = exp_ready;
    send_raw(mk_frame(c, kind == 2, kind == 1), 11, lat);
    if (valid) model_key(c);
    else exp_ferr++;
    repeat (4) @(negedge clk);
    check({tag, "_cnt"}, 32'(digit_count), 32'(q.size()));
    check({tag, "_ready"}, n_ready, exp_ready);
    check({tag, "_ferr"}, n_ferr, exp_ferr);
    check({tag, "_user"}, 32'(userInt), 32'(exp_user));
    if (exp_ready != r0 || !valid) check({tag, "_lat"}, lat, SS + 2);
  endtask

  task automatic model_reset();
    q.delete();
    m_skip = 1'b0;
    m_ext = 1'b0;
    exp_user = '0;
  endtask

  initial begin
    int lat;
    int kind;
    repeat (3) @(negedge clk);
    check("rst_user", 32'(userInt), 32'd0);
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_cnt", 32'(digit_count), 32'd0);
    check("rst_ferr", 32'(frame_err), 32'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    key(8'h16, 0, "k1"); key(8'h1E, 0, "k2"); key(8'h26, 0, "k3"); key(8'h25, 0, "k4");
    check("basic_user", 32'(userInt), 32'h4321);
    check("basic_ready", n_ready, 1);

    key(8'h16, 0, "b1"); key(8'hF0, 0, "bF0"); key(8'h16, 0, "bbrk"); key(8'h1E, 0, "b2");
    key(8'h66, 0, "bbs"); key(8'h2E, 0, "b5"); key(8'h36, 0, "b6"); key(8'h3D, 0, "b7");
    check("bs_user", 32'(userInt), 32'h7651);
    check("bs_ready", n_ready, 2);

    key(8'h16, 2, "par");
    check("par_cnt", 32'(digit_count), PAR_EN ? 32'd0 : 32'd1);
    key(8'h66, 0, "par_bs");
    key(8'h66, 0, "bs_empty");
    check("bs_empty_ferr", n_ferr, PAR_EN ? 1 : 0);

    send_raw(mk_frame(8'h1C, 1'b0, 1'b0), 5, lat);
    repeat (TMO + 2) @(negedge clk);
    exp_ferr++;
    check("tmo_ferr", n_ferr, exp_ferr);
    check("tmo_cnt", 32'(digit_count), 32'd0);
    key(8'h45, 0, "tmo0");
    check("tmo_next_cnt", 32'(digit_count), 32'd1);
    key(8'h1E, 0, "t2"); key(8'h26, 0, "t3"); key(8'h25, 0, "t4");
    check("tmo_user", 32'(userInt), 32'h4320);

    key(8'hE0, 0, "e0"); key(8'h16, 0, "e16");
    check("ext_cnt", 32'(digit_count), 32'd0);
    key(8'h16, 0, "ext_norm");
    check("ext_norm_cnt", 32'(digit_count), 32'd1);

    send_raw(mk_frame(8'h1E, 1'b0, 1'b0), 6, lat);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    model_reset();
    check("mid_rst_user", 32'(userInt), 32'd0);
    check("mid_rst_ready", 32'(ready), 32'd0);
    check("mid_rst_cnt", 32'(digit_count), 32'd0);
    check("mid_rst_ferr", 32'(frame_err), 32'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    key(8'h1E, 0, "post_rst");
    check("post_rst_cnt", 32'(digit_count), 32'd1);
    key(8'h26, 0, "p3"); key(8'h25, 0, "p4"); key(8'h16, 0, "p1");
    check("post_rst_user", 32'(userInt), 32'h1432);

    for (int i = 0; i < 60; i++) begin
      kind = $urandom_range(0, 9);
      kind = (kind == 0) ? 1 : (kind == 1) ? 2 : 0;
      key(pool[$urandom_range(0, 14)], kind, "rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
